// File: rtl/piso_tx_sched.sv
// Round-robin scheduler that feeds a shared parallel-load shift register and
// emits ser_valid/ser_last/ser_owner strobes aligned to the register's sout.
module piso_tx_sched #(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 2,
  localparam int OW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*WIDTH-1:0] i_req_data,
  output logic [NREQ-1:0]       o_ack,
  output logic                  o_sr_load,
  output logic [WIDTH-1:0]      o_sr_din,
  output logic                  o_busy,
  output logic                  o_ser_valid,
  output logic                  o_ser_last,
  output logic [OW-1:0]         o_ser_owner
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t           r_state;
  logic [OW-1:0]    r_ptr;
  logic [OW-1:0]    r_win;
  logic [CW-1:0]    r_cnt;
  logic [NREQ-1:0]  r_ack;
  logic             r_load;
  logic [WIDTH-1:0] r_din;
  logic             r_busy;
  logic             r_ser_valid;
  logic             r_ser_last;
  logic [OW-1:0]    r_ser_owner;

  logic             w_grant;
  logic [OW-1:0]    w_win;
  logic [WIDTH-1:0] w_word;
  int               w_d;
  int               w_best;

  // Winner is the requester with the smallest forward distance from r_ptr.
  always_comb begin
    w_win  = '0;
    w_word = '0;
    w_d    = 0;
    w_best = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      w_d = (i >= int'(r_ptr)) ? (i - int'(r_ptr)) : (i + NREQ - int'(r_ptr));
      if (i_req[i] && (w_d < w_best)) begin
        w_best = w_d;
        w_win  = OW'(i);
        w_word = i_req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_grant = (|i_req) &&
                   ((r_state == IDLE) || ((r_state == SHIFT) && (r_cnt == LAST)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_win       <= '0;
      r_cnt       <= '0;
      r_ack       <= '0;
      r_load      <= 1'b0;
      r_din       <= '0;
      r_busy      <= 1'b0;
      r_ser_valid <= 1'b0;
      r_ser_last  <= 1'b0;
      r_ser_owner <= '0;
    end else begin
      // sout trails the shift cycle by one edge, so the strobes are delayed copies
      r_ser_valid <= (r_state == SHIFT);
      r_ser_last  <= (r_state == SHIFT) && (r_cnt == LAST);
      r_ser_owner <= r_win;
      r_ack       <= '0;
      r_load      <= 1'b0;
      case (r_state)
        LOAD: begin
          r_state <= SHIFT;
          r_cnt   <= '0;
          r_ptr   <= (r_win == OW'(NREQ - 1)) ? '0 : r_win + OW'(1);
        end
        SHIFT: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: ;
      endcase
      if (w_grant) begin
        r_state <= LOAD;
        r_busy  <= 1'b1;
        r_win   <= w_win;
        r_din   <= w_word;
        r_load  <= 1'b1;
        r_ack   <= NREQ'(1) << w_win;
      end
    end
  end

  assign o_ack       = r_ack;
  assign o_sr_load   = r_load;
  assign o_sr_din    = r_din;
  assign o_busy      = r_busy;
  assign o_ser_valid = r_ser_valid;
  assign o_ser_last  = r_ser_last;
  assign o_ser_owner = r_ser_owner;

endmodule

// File: tb/tb_piso_tx_sched.sv
// Scoreboard bench for piso_tx_sched: a cycle-count round-robin model predicts
// loads and frames; monitors compare the DUT and a shift-register model.
module tb_piso_tx_sched;
  localparam int W  = 4;
  localparam int N  = 3;
  localparam int OW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   ack;
  logic           sr_load, busy, ser_valid, ser_last;
  logic [W-1:0]   sr_din;
  logic [OW-1:0]  ser_owner;

  piso_tx_sched #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .reset(reset), .i_req(req), .i_req_data(req_data),
    .o_ack(ack), .o_sr_load(sr_load), .o_sr_din(sr_din), .o_busy(busy),
    .o_ser_valid(ser_valid), .o_ser_last(ser_last), .o_ser_owner(ser_owner));

  always #5 clk = ~clk;

  // Shared shift register: holds sout on load, otherwise shifts MSB out.
  logic [W-1:0] sr;
  logic         sout;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0; sout <= 1'b0;
    end else if (sr_load) begin
      sr <= sr_din;
    end else begin
      sout <= sr[W-1];
      sr   <= {sr[W-2:0], 1'b0};
    end
  end

  typedef struct {int cyc; int own; logic [W-1:0] word;} frame_t;
  frame_t lq[$];
  frame_t sq[$];
  int cyc, nvec, nerr, m_rr, m_next, ll, nbits, mode;
  bit m_idle;
  logic [W-1:0] sbits;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_idle = 1; m_next = 0; ll = -100; nbits = 0;
    lq.delete(); sq.delete();
  endtask

  // Arbitration in cycle t (idle, or the last shift cycle) yields a load at t+1.
  task automatic model_arb(int t);
    if (!(m_idle || t == m_next)) return;
    if (req == '0) begin m_idle = 1; return; end
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (req[i]) begin
        frame_t f;
        f.cyc = t + 1; f.own = i; f.word = req_data[i*W +: W];
        lq.push_back(f); sq.push_back(f);
        m_rr = (i + 1) % N; m_next = t + 1 + W; m_idle = 0; ll = t + 1;
        break;
      end
    end
  endtask

  task automatic check_cycle();
    bit el;
    el = (lq.size() > 0) && (lq[0].cyc == cyc);
    chk("sr_load", sr_load, el);
    chk("ack", ack, el ? (1 << lq[0].own) : 0);
    if (el) begin
      chk("sr_din", sr_din, lq[0].word);
      void'(lq.pop_front());
    end
    chk("busy", busy, (cyc >= ll) && (cyc <= ll + W));
    if (ser_valid) begin
      if (sq.size() == 0) chk("ser_valid_idle", ser_valid, 0);
      else begin
        chk("ser_owner", ser_owner, sq[0].own);
        sbits = {sbits[W-2:0], sout};
        nbits++;
        if (ser_last) begin
          chk("frame_bits", nbits, W);
          chk("frame_word", sbits, sq[0].word);
          chk("ser_last_cyc", cyc, sq[0].cyc + W + 1);
          void'(sq.pop_front());
          nbits = 0;
        end
      end
    end else chk("ser_last_no_valid", ser_last, 0);
  endtask

  task automatic update_req();
    for (int i = 0; i < N; i++) begin
      if (mode >= 1 && ack[i]) req[i] = 1'b0;
      if (mode == 2) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_data[i*W +: W] = W'($urandom);
        end else if (req[i] && !ack[i] && $urandom_range(0, 29) == 0) req[i] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset(); else model_arb(cyc);
    cyc++;
    @(negedge clk);
    check_cycle();
    update_req();
  endtask

  task automatic check_zero();
    chk("rst_ack", ack, 0);
    chk("rst_sr_load", sr_load, 0);
    chk("rst_sr_din", sr_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_ser_last", ser_last, 0);
    chk("rst_ser_owner", ser_owner, 0);
  endtask

  task automatic wait_load();
    for (int k = 0; k < 20 && !sr_load; k++) cycle();
    chk("wait_load", sr_load, 1);
  endtask

  initial begin
    reset = 1'b1; req = '0; req_data = '0; mode = 1;
    cyc = 0; nvec = 0; nerr = 0; sbits = '0;
    model_reset();
    repeat (2) cycle();
    check_zero();
    reset = 1'b0;
    repeat (20) cycle();

    // Single frame from requester 0.
    req_data[3:0] = 4'b1011; req = 3'b001; mode = 1;
    repeat (12) cycle();

    // Two requesters held: alternating back-to-back frames.
    req_data = {4'h0, 4'h5, 4'hA}; req = 3'b011; mode = 0;
    repeat (22) cycle();
    req = '0; repeat (8) cycle();

    // Requester 1 rises mid-frame and is picked at the last shift cycle.
    req_data[3:0] = 4'h3; req = 3'b001; mode = 1;
    wait_load();
    repeat (2) cycle();
    req_data[7:4] = 4'h6; req[1] = 1'b1;
    repeat (14) cycle();

    // Asynchronous reset at shift counter 2, then pointer restarts at 0.
    req_data = {4'h0, 4'hC, 4'h9}; req = 3'b011; mode = 0;
    wait_load();
    repeat (3) cycle();
    #2 reset = 1'b1;
    #1 check_zero();
    model_reset();
    repeat (2) cycle();
    reset = 1'b0;
    repeat (12) cycle();
    req = '0; repeat (8) cycle();

    // Wrap-around: pointer at 1 with requests on 0 and 2.
    req_data = {4'hE, 4'h0, 4'h7}; req = 3'b001; mode = 1;
    repeat (10) cycle();
    req = 3'b101; mode = 0;
    repeat (18) cycle();
    req = '0; repeat (8) cycle();

    // Random traffic, then let pending requests drain.
    mode = 2;
    repeat (800) cycle();
    mode = 1;
    repeat (40) cycle();
    req = '0;
    repeat (10) cycle();

    chk("loads_drained", lq.size(), 0);
    chk("frames_drained", sq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/piso_tx_sched.md
Name: piso_tx_sched

Overview:
- Round-robin scheduler and sequencer for the shared 4-bit parallel-load shift register (load/din in; sout/dout out).
- Arbitrates between NREQ requesters, each presenting a parallel word.
- Drives the register's load and din, then times the serial shift-out.
- Emits frame-qualifying strobes (ser_valid, ser_last, ser_owner) aligned to the register's sout, so downstream logic can sample the serial stream without its own counter.

Parameters:
- WIDTH, 4, word width; must match the shift register width.
- NREQ, 2, number of requesters (2..8).
- OW, max(1, ceil(log2(NREQ))), width of the owner index (derived, not overridable).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request; the requester holds it and its word stable until acked.
- req_data  in  NREQ*WIDTH  requester i's word in bits [i*WIDTH +: WIDTH].
- ack  out  NREQ  one-cycle pulse; the word of requester i is consumed this cycle.
- sr_load  out  1  to shift register load.
- sr_din  out  WIDTH  to shift register din.
- busy  out  1  frame in progress (LOAD or SHIFT state).
- ser_valid  out  1  register sout carries a valid frame bit this cycle.
- ser_last  out  1  the current sout bit is the LSB (final bit) of the frame.
- ser_owner  out  OW  index of the requester whose bit is on sout; valid while ser_valid=1.

Behaviour:
- Reset (async, any state): state=IDLE; rr pointer=0; bit counter=0.
  - Outputs ack=0, sr_load=0, sr_din=0, busy=0, ser_valid=0, ser_last=0, ser_owner=0.
  - A frame interrupted by reset is abandoned and not replayed.
- States: IDLE, LOAD, SHIFT.
- IDLE:
  - If any req is set, grant the first requesting index at or after the rr pointer, wrapping modulo NREQ.
  - Register the winner index and its word, then go to LOAD.
  - If no req is set, stay in IDLE.
- LOAD (exactly 1 cycle):
  - sr_load=1; sr_din=granted word; ack[winner]=1; all other ack bits=0.
  - rr pointer <= winner+1 (mod NREQ); counter <= 0; go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - sr_load=0; sr_din is held at the granted word (don't-care to the register).
  - Counter increments each cycle.
  - On the cycle where counter==WIDTH-1, the next state is decided by the same arbitration as IDLE:
    - any req set -> next state LOAD with the new winner (back-to-back frames);
    - otherwise -> IDLE.
- Frame period: WIDTH+1 cycles. Back-to-back throughput is one word per WIDTH+1 cycles.
- Serial alignment: the register updates sout one edge after each shift cycle, so sout bits trail SHIFT by one cycle. With the LOAD cycle as c0:
  - ser_valid=1 in cycles c2..c(WIDTH+1), carrying MSB first;
  - ser_last=1 only in c(WIDTH+1);
  - ser_owner = the frame's winner, held through c(WIDTH+1).
- Implement ser_valid, ser_last and ser_owner as registered copies of (state==SHIFT), (counter==WIDTH-1) and the winner index.
- Overlap rule: a back-to-back LOAD falls in c(WIDTH+1).
  - The register holds sout during a load, so the LSB of frame N stays valid in that cycle while frame N+1 loads.
  - The first bit of frame N+1 appears at c(WIDTH+3).
  - There is therefore a one-cycle ser_valid=0 gap between frames.
- Request timing:
  - A req deasserted before its ack is simply not granted; no state is held for it.
  - A req is sampled only at arbitration points (IDLE cycles, or the last SHIFT cycle).
  - A req rising during SHIFT waits for the next arbitration point.
- Fairness: a requester that keeps req high is served at most once per NREQ frames while others are requesting.
- busy=1 in LOAD and SHIFT, 0 in IDLE. The trailing ser_valid cycle after SHIFT may occur with busy=0.
- The shift register shares the same reset, so both blocks return to idle together.

Test Plan:
- Reset with req=0 -> all outputs 0; no sr_load for 20 cycles.
- req=01, req_data[3:0]=4'b1011:
  - c0 sr_load=1, sr_din=1011, ack=01;
  - ser_valid in c2..c5 with sout 1,0,1,1;
  - ser_last only in c5; ser_owner=0; returns to IDLE.
- req=11 held, words 4'hA (req0) and 4'h5 (req1):
  - grants alternate 0,1,0,1, with a LOAD every 5 cycles;
  - ser_owner alternates;
  - one-cycle ser_valid gap between frames.
- Last-shift arbitration: req1 asserts during SHIFT of req0's frame -> next LOAD occurs exactly in c5 for req1; ack[1] pulses in c5 only.
- Reset asserted asynchronously in SHIFT (counter=2) -> outputs 0 immediately; with req held after release, the rr pointer restarts at 0 and requester 0 is granted first.
- NREQ=3, req=101 with pointer at 1 -> requester 2 is granted, then requester 0, then requester 2 (wrap-around check).
